window_stream_buffer: RTL and testbench
=======================================

# window_stream_buffer

Parametrised sliding-window line buffer for the custom-logic image pipeline. It accepts a raster pixel stream with a valid/ready handshake and emits WIN×WIN pixel windows with top-left coordinates and Bayer parity. Stride is selectable: overlapping windows (stride 1) or non-overlapping tiles (stride WIN). It sits between the SDRAM read path and the RGGB reorder / filter stage, replacing the fixed 2×2 window buffer, and adds window size, pixel width, stride mode and backpressure.

## Interface
- PIXEL_W, 8, bits per pixel
- MAX_COLS, 4096, maximum image width; sets line-buffer depth
- WIN, 2, window edge; legal values 2 or 3 only
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches configuration; honoured only in IDLE
- image_width  in  13  columns W, sampled on start
- image_height  in  13  rows H, sampled on start
- stride_sel  in  1  0 = stride 1, 1 = stride WIN; sampled on start
- pix_data  in  PIXEL_W  raster pixel, row-major order
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  block accepts pixel this cycle
- win_data  out  WIN*WIN*PIXEL_W  window; element k = r*WIN+c (r = row within window, 0 = top; c = column, 0 = left); element 0 in the LSBs
- win_row  out  13  top-left row of window
- win_col  out  13  top-left column of window
- row_par  out  1  win_row[0]
- col_par  out  1  win_col[0]
- win_valid  out  1  window output valid
- win_ready  in  1  downstream accepts window
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- cfg_err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, RUN, FLUSH.
  - IDLE → RUN on start when W ≥ 1, H ≥ 1, W ≤ MAX_COLS.
  - Otherwise start pulses cfg_err and the block stays in IDLE.
  - start outside IDLE is ignored.
- Counters r (row) and c (column) are 13 bits and reset to 0 on start. An accepted pixel is the handshake `pix_valid & pix_ready`. On each accepted pixel:
  - c increments.
  - At c = W−1, c wraps to 0 and r increments.
- Line buffers:
  - WIN−1 row memories, MAX_COLS × PIXEL_W each, addressed by c.
  - On an accepted pixel, column c shifts up: buffer[0][c] ← buffer[1][c] (WIN = 3 only), last buffer[c] ← pix_data.
  - Line-buffer contents are not reset.
- Window registers:
  - A WIN×WIN shift array.
  - On an accepted pixel, each row shifts left by one.
  - The new right column is {buffer rows at c, pix_data}, top to bottom.
- Emission for an accepted pixel at (r, c), where (r, c) is the window's bottom-right:
  - Requires r ≥ WIN−1 and c ≥ WIN−1.
  - stride_sel = 1 additionally requires (r+1) mod WIN = 0 and (c+1) mod WIN = 0. Use mod-WIN phase counters; no divider.
  - win_row = r−WIN+1, win_col = c−WIN+1.
- Window count per frame:
  - stride 1: (H−WIN+1)(W−WIN+1).
  - stride WIN: ⌊H/WIN⌋·⌊W/WIN⌋.
  - If W < WIN or H < WIN, the frame emits zero windows. All W·H pixels are still consumed.
- pix_ready = (state = RUN) & (~win_valid | win_ready). This applies to every pixel, including non-emitting ones.
- After the last pixel (r = H−1, c = W−1) is accepted, go to FLUSH.
  - FLUSH → IDLE when ~win_valid, or when win_valid & win_ready.
  - frame_done pulses on that transition cycle.

## Timing
- Reset values: pix_ready 0, win_valid 0, win_data 0, win_row 0, win_col 0, row_par 0, col_par 0, busy 0, frame_done 0, cfg_err 0; state IDLE; counters 0.
- Reset mid-frame aborts: the pending window is dropped and no frame_done pulse is issued.
- pix_ready may rise the cycle after start.
- Latency: window registered; win_valid is high the cycle after the bottom-right pixel is accepted.
- win_valid and the window fields hold until win_valid & win_ready.
- Accept and emit in the same cycle is allowed when win_ready = 1; throughput is 1 pixel per clock with no bubbles.
- win_ready low stalls input through pix_ready with zero pixel loss.
- frame_done comes 1 cycle after the last accepted pixel if no window is pending; otherwise on the handoff cycle of the final window.
- An empty frame (W < WIN or H < WIN) asserts frame_done one cycle after its last pixel.

## Test plan
- WIN=2, stride 1, W=H=4, pixel = 4r+c, win_ready=1 → 9 windows. First window {0,1,4,5} (element 0 = 0) at (0,0). Last window {10,11,14,15} at (2,2). frame_done once.
- WIN=2, stride_sel=1, same image → 4 windows at (0,0),(0,2),(2,0),(2,2). Parities (0,0) on all. Window (2,2) = {10,11,14,15}.
- WIN=3, stride 1, W=5, H=4, pixel = 5r+c → 6 windows. First {0,1,2,5,6,7,10,11,12}. Last at (1,2) = {7,8,9,12,13,14,17,18,19}.
- Backpressure: win_ready low for 5 cycles mid-row → pix_ready low the same cycles. Window held stable. Full sequence matches the no-stall run.
- start with W=0, or W=MAX_COLS+1 → cfg_err 1-cycle pulse, busy stays 0, pix_ready stays 0.
- rst asserted after 7 pixels of a 4×4 frame → all outputs 0 next cycle. A new start with a fresh frame produces the correct 9 windows.

Source files
------------

// File: rtl/window_stream_buffer.sv
// window_stream_buffer
// Sliding WINxWIN window line buffer for a raster pixel stream.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start, image_width/height, stride_sel   frame configuration (latched on start in IDLE)
//   pix_data/pix_valid/pix_ready            raster pixel input handshake
//   win_data/win_row/win_col/row_par/col_par/win_valid/win_ready  window output handshake
//   busy, frame_done, cfg_err               status
// win_data element k = r*WIN+c (top-left window pixel in the LSBs).
module window_stream_buffer #(
  parameter int PIXEL_W  = 8,
  parameter int MAX_COLS = 4096,
  parameter int WIN      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [12:0]                image_width,
  input  logic [12:0]                image_height,
  input  logic                       stride_sel,
  input  logic [PIXEL_W-1:0]         pix_data,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [WIN*WIN*PIXEL_W-1:0] win_data,
  output logic [12:0]                win_row,
  output logic [12:0]                win_col,
  output logic                       row_par,
  output logic                       col_par,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       cfg_err
);
  localparam int          AW      = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int          NLB     = WIN - 1;
  localparam logic [12:0] MAXC    = 13'(MAX_COLS);
  localparam logic [12:0] WLIM    = 13'(WIN - 1);
  localparam logic [1:0]  PH_LAST = 2'(WIN - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [12:0] w_q, h_q, r_q, c_q;
  logic        stride_q;
  logic [1:0]  rph_q, cph_q;   // row/col phase mod WIN for tiled stride

  logic [PIXEL_W-1:0] lb [NLB][MAX_COLS];
  logic [WIN-1:0][WIN-1:0][PIXEL_W-1:0] win_q;   // [row][col]
  logic [WIN-1:0][PIXEL_W-1:0]          col_in;

  logic          cfg_ok, start_ok, accept, last_col, last_pix, emit;
  logic [AW-1:0] addr;

  assign cfg_ok   = (image_width != 13'd0) & (image_height != 13'd0) & (image_width <= MAXC);
  assign start_ok = start & (state == IDLE) & cfg_ok;
  assign accept   = pix_valid & pix_ready;
  assign last_col = (c_q == w_q - 13'd1);
  assign last_pix = last_col & (r_q == h_q - 13'd1);
  assign addr     = c_q[AW-1:0];
  assign emit     = accept & (r_q >= WLIM) & (c_q >= WLIM) &
                    (~stride_q | ((rph_q == PH_LAST) & (cph_q == PH_LAST)));

  // Input stalls whenever a window is pending and not being taken.
  assign pix_ready = (state == RUN) & (~win_valid | win_ready);
  assign busy      = (state != IDLE);
  assign row_par   = win_row[0];
  assign col_par   = win_col[0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = RUN;
      RUN:   if (accept & last_pix) state_nxt = FLUSH;
      FLUSH: if (~win_valid | win_ready) begin
        state_nxt  = IDLE;
        frame_done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration and raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0; h_q <= '0; stride_q <= 1'b0;
      r_q <= '0; c_q <= '0; rph_q <= '0; cph_q <= '0;
    end else if (start_ok) begin
      w_q <= image_width; h_q <= image_height; stride_q <= stride_sel;
      r_q <= '0; c_q <= '0; rph_q <= '0; cph_q <= '0;
    end else if (accept) begin
      if (last_col) begin
        c_q   <= '0;
        cph_q <= '0;
        r_q   <= r_q + 13'd1;
        rph_q <= (rph_q == PH_LAST) ? 2'd0 : rph_q + 2'd1;
      end else begin
        c_q   <= c_q + 13'd1;
        cph_q <= (cph_q == PH_LAST) ? 2'd0 : cph_q + 2'd1;
      end
    end
  end

  // Line buffers: column c moves up one row; newest row takes the pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NLB - 1; i++) lb[i][addr] <= lb[i+1][addr];
      lb[NLB-1][addr] <= pix_data;
    end
  end

  always_comb begin
    col_in = '0;
    for (int i = 0; i < NLB; i++) col_in[i] = lb[i][addr];
    col_in[WIN-1] = pix_data;
  end

  // Window shift array doubles as the output register: it only moves on
  // an accept, and accepts are blocked while a window waits un-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN - 1; j++) win_q[i][j] <= win_q[i][j+1];
        win_q[i][WIN-1] <= col_in[i];
      end
    end
  end

  genvar gr, gc;
  generate
    for (gr = 0; gr < WIN; gr++) begin : g_row
      for (gc = 0; gc < WIN; gc++) begin : g_col
        assign win_data[(gr*WIN+gc)*PIXEL_W +: PIXEL_W] = win_q[gr][gc];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= start & (state == IDLE) & ~cfg_ok;
      if (emit) begin
        win_valid <= 1'b1;
        win_row   <= r_q - WLIM;
        win_col   <= c_q - WLIM;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_window_stream_buffer.sv
module tb_window_stream_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: WIN=2 instance, index 1: WIN=3 instance
  logic        start [2];
  logic [12:0] iw [2], ih [2];
  logic        ss [2], pv [2], wr [2];
  logic [7:0]  pd [2];
  logic        prdy [2], wv [2], bsy [2], fd [2], ce [2], rp [2], cp [2];
  logic [12:0] wrow [2], wcol [2];
  logic [31:0] wd2;
  logic [71:0] wd3;
  logic [71:0] wd [2];
  assign wd[0] = {40'd0, wd2};
  assign wd[1] = wd3;

  window_stream_buffer #(.PIXEL_W(8), .MAX_COLS(4096), .WIN(2)) dut2 (
    .clk(clk), .rst(rst), .start(start[0]), .image_width(iw[0]), .image_height(ih[0]),
    .stride_sel(ss[0]), .pix_data(pd[0]), .pix_valid(pv[0]), .pix_ready(prdy[0]),
    .win_data(wd2), .win_row(wrow[0]), .win_col(wcol[0]), .row_par(rp[0]), .col_par(cp[0]),
    .win_valid(wv[0]), .win_ready(wr[0]), .busy(bsy[0]), .frame_done(fd[0]), .cfg_err(ce[0]));

  window_stream_buffer #(.PIXEL_W(8), .MAX_COLS(4096), .WIN(3)) dut3 (
    .clk(clk), .rst(rst), .start(start[1]), .image_width(iw[1]), .image_height(ih[1]),
    .stride_sel(ss[1]), .pix_data(pd[1]), .pix_valid(pv[1]), .pix_ready(prdy[1]),
    .win_data(wd3), .win_row(wrow[1]), .win_col(wcol[1]), .row_par(rp[1]), .col_par(cp[1]),
    .win_valid(wv[1]), .win_ready(wr[1]), .busy(bsy[1]), .frame_done(fd[1]), .cfg_err(ce[1]));

  int n_tests = 0;
  int n_fail  = 0;

  logic [71:0] q_data [$];
  int          q_row [$], q_col [$];
  logic        q_rp [$], q_cp [$];
  int          fd_cnt;
  logic [71:0] ref_data [$];
  int          ref_row [$], ref_col [$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one whole frame into instance s (pixel value = raster index),
  // capturing every handed-off window. Optionally stalls win_ready for
  // 5 cycles once pixel 6 is next (a window is pending at that point).
  task automatic run_frame(input int s, input int w, input int h, input logic str, input bit stall);
    int p, stl, post;
    bit stdone;
    logic [71:0] held;
    q_data.delete(); q_row.delete(); q_col.delete(); q_rp.delete(); q_cp.delete();
    fd_cnt = 0; p = 0; stl = 0; post = 0; stdone = 0; held = '0;
    @(negedge clk);
    start[s] = 1'b1; iw[s] = 13'(w); ih[s] = 13'(h); ss[s] = str;
    @(negedge clk);
    start[s] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pv[s] = (p < w * h);
      pd[s] = 8'(p);
      if (stall && !stdone && stl == 0 && p == 6) begin
        stl  = 5;
        held = wd[s];
        chk("stall_held_window", held, 72'h05040100);
      end
      wr[s] = (stl == 0);
      #1;
      if (stl > 0) begin
        chk("stall_pix_ready", 72'(prdy[s]), 72'd0);
        chk("stall_win_valid", 72'(wv[s]), 72'd1);
        chk("stall_win_hold", wd[s], held);
        stl--;
        if (stl == 0) stdone = 1;
      end
      if (wv[s] && wr[s]) begin
        q_data.push_back(wd[s]); q_row.push_back(int'(wrow[s])); q_col.push_back(int'(wcol[s]));
        q_rp.push_back(rp[s]); q_cp.push_back(cp[s]);
      end
      if (fd[s]) fd_cnt++;
      if (pv[s] && prdy[s]) p++;
      if (fd_cnt > 0) post++;
      if (post > 3) break;
      @(negedge clk);
    end
    pv[s] = 1'b0;
    wr[s] = 1'b1;
    @(negedge clk);
    chk("frame_done_count", 72'(fd_cnt), 72'd1);
    chk("busy_after_frame", 72'(bsy[s]), 72'd0);
  endtask

  // Checks captured stride-1 windows against the raster-index image.
  task automatic check_all(input string tag, input int w, input int h, input int win);
    int nc, r0, c0;
    logic [71:0] e;
    nc = w - win + 1;
    chk({tag, "_count"}, 72'(q_data.size()), 72'((h - win + 1) * nc));
    for (int k = 0; k < q_data.size(); k++) begin
      r0 = k / nc; c0 = k % nc;
      e = '0;
      for (int i = 0; i < win; i++)
        for (int j = 0; j < win; j++)
          e[(i*win+j)*8 +: 8] = 8'((r0 + i) * w + c0 + j);
      chk({tag, "_data"}, q_data[k], e);
      chk({tag, "_row"}, 72'(q_row[k]), 72'(r0));
      chk({tag, "_col"}, 72'(q_col[k]), 72'(c0));
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int s);
    chk({tag, "_pix_ready"}, 72'(prdy[s]), 72'd0);
    chk({tag, "_win_valid"}, 72'(wv[s]), 72'd0);
    chk({tag, "_win_data"}, wd[s], 72'd0);
    chk({tag, "_win_row"}, 72'(wrow[s]), 72'd0);
    chk({tag, "_win_col"}, 72'(wcol[s]), 72'd0);
    chk({tag, "_pars"}, 72'({rp[s], cp[s]}), 72'd0);
    chk({tag, "_busy"}, 72'(bsy[s]), 72'd0);
    chk({tag, "_flags"}, 72'({fd[s], ce[s]}), 72'd0);
  endtask

  initial begin
    int p;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s] = 0; iw[s] = 0; ih[s] = 0; ss[s] = 0; pv[s] = 0; pd[s] = 0; wr[s] = 1;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset2", 0);
    check_idle_outputs("reset3", 1);
    rst = 1'b0;

    // WIN=2, stride 1, 4x4
    run_frame(0, 4, 4, 1'b0, 0);
    check_all("w2s1", 4, 4, 2);
    if (q_data.size() == 9) begin
      chk("w2s1_first", q_data[0], 72'h05040100);
      chk("w2s1_last", q_data[8], 72'h0f0e0b0a);
      chk("w2s1_last_pos", 72'({q_row[8], q_col[8]}), 72'({32'd2, 32'd2}));
    end
    ref_data = q_data; ref_row = q_row; ref_col = q_col;

    // WIN=2, stride WIN, 4x4
    run_frame(0, 4, 4, 1'b1, 0);
    chk("w2s2_count", 72'(q_data.size()), 72'd4);
    if (q_data.size() == 4) begin
      chk("w2s2_d0", q_data[0], 72'h05040100);
      chk("w2s2_d1", q_data[1], 72'h07060302);
      chk("w2s2_d2", q_data[2], 72'h0d0c0908);
      chk("w2s2_d3", q_data[3], 72'h0f0e0b0a);
      chk("w2s2_pos0", 72'({q_row[0], q_col[0]}), 72'({32'd0, 32'd0}));
      chk("w2s2_pos1", 72'({q_row[1], q_col[1]}), 72'({32'd0, 32'd2}));
      chk("w2s2_pos2", 72'({q_row[2], q_col[2]}), 72'({32'd2, 32'd0}));
      chk("w2s2_pos3", 72'({q_row[3], q_col[3]}), 72'({32'd2, 32'd2}));
      for (int k = 0; k < 4; k++) chk("w2s2_par", 72'({q_rp[k], q_cp[k]}), 72'd0);
    end

    // WIN=3, stride 1, W=5 H=4
    run_frame(1, 5, 4, 1'b0, 0);
    check_all("w3s1", 5, 4, 3);
    if (q_data.size() == 6) begin
      chk("w3s1_first", q_data[0], 72'h0c0b0a070605020100);
      chk("w3s1_last", q_data[5], 72'h1312110e0d0c090807);
      chk("w3s1_last_pos", 72'({q_row[5], q_col[5]}), 72'({32'd1, 32'd2}));
      chk("w3s1_last_par", 72'({q_rp[5], q_cp[5]}), 72'b10);
    end

    // Backpressure: same windows as the unstalled run
    run_frame(0, 4, 4, 1'b0, 1);
    chk("bp_count", 72'(q_data.size()), 72'(ref_data.size()));
    for (int k = 0; k < q_data.size() && k < ref_data.size(); k++) begin
      chk("bp_data", q_data[k], ref_data[k]);
      chk("bp_pos", 72'({q_row[k], q_col[k]}), 72'({ref_row[k], ref_col[k]}));
    end

    // Empty frame: W < WIN emits nothing but still ends cleanly
    run_frame(0, 1, 4, 1'b0, 0);
    chk("empty_count", 72'(q_data.size()), 72'd0);

    // Rejected configurations
    @(negedge clk); start[0] = 1; iw[0] = 13'd0; ih[0] = 13'd4;
    @(negedge clk); start[0] = 0;
    chk("cfg_w0_err", 72'(ce[0]), 72'd1);
    chk("cfg_w0_busy", 72'(bsy[0]), 72'd0);
    chk("cfg_w0_ready", 72'(prdy[0]), 72'd0);
    @(negedge clk);
    chk("cfg_w0_pulse", 72'(ce[0]), 72'd0);
    start[0] = 1; iw[0] = 13'd4097; ih[0] = 13'd4;
    @(negedge clk); start[0] = 0;
    chk("cfg_wmax_err", 72'(ce[0]), 72'd1);
    chk("cfg_wmax_busy", 72'(bsy[0]), 72'd0);
    chk("cfg_wmax_ready", 72'(prdy[0]), 72'd0);
    @(negedge clk);
    chk("cfg_wmax_pulse", 72'(ce[0]), 72'd0);

    // Reset after 7 pixels of a 4x4 frame
    start[0] = 1; iw[0] = 13'd4; ih[0] = 13'd4; ss[0] = 0;
    @(negedge clk); start[0] = 0;
    p = 0;
    for (int cyc = 0; cyc < 50 && p < 7; cyc++) begin
      pv[0] = 1; pd[0] = 8'(p);
      #1;
      if (prdy[0]) p++;
      @(negedge clk);
    end
    pv[0] = 0;
    chk("abort_pixels", 72'(p), 72'd7);
    chk("abort_pending", 72'(wv[0]), 72'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort", 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 72'(fd[0]), 72'd0);
    end

    run_frame(0, 4, 4, 1'b0, 0);
    check_all("after_abort", 4, 4, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
